// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared state encoding, port id type and RISC-V load/store size codes
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef logic port_id_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant that favours the port not served last
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  port_id_t   last_grant,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] && (!valid[1] || last_grant);
    assign grant[1] = valid[1] && (!valid[0] || !last_grant);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two requesters onto one data memory port, one transaction in flight
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic                  req0_we,
    input  logic                  req1_we,
    input  logic [DM_ADDRESS-1:0] req0_addr,
    input  logic [DM_ADDRESS-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    input  logic [DATA_W-1:0]     req1_wdata,
    input  logic [2:0]            req0_funct3,
    input  logic [2:0]            req1_funct3,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_W-1:0]     rsp0_rdata,
    output logic [DATA_W-1:0]     rsp1_rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);
    state_t state, next;
    port_id_t last_grant, port;
    logic we, last_rd;
    logic [2:0] cnt;
    logic [1:0] grant;
    logic [DATA_W-1:0] rsp_rdata;

    rr_arb2 u_arb (.valid({req1_valid, req0_valid}), .last_grant(last_grant), .grant(grant));

    assign rsp0_rdata = rsp_rdata;
    assign rsp1_rdata = rsp_rdata;

    always_ff @(posedge clk)
        state <= reset ? IDLE : next;

    always_comb begin
        next = state;
        req0_ready = state == IDLE && grant[0];
        req1_ready = state == IDLE && grant[1];
        MemWrite = state == ISSUE && we;
        MemRead = (state == ISSUE || state == WAIT) && !we;
        rsp0_valid = state == RESP && port == 1'b0;
        rsp1_valid = state == RESP && port == 1'b1;
        // rd is address-combinational, so it is taken on the edge closing the last read cycle
        last_rd = !we && (state == ISSUE ? RD_LATENCY == 1 : state == WAIT && cnt == 3'd1);
        case (state)
            IDLE:    next = (req0_ready || req1_ready) ? ISSUE : IDLE;
            ISSUE:   next = (we || RD_LATENCY == 1) ? RESP : WAIT;
            WAIT:    next = cnt == 3'd1 ? RESP : WAIT;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            port <= 1'b0;
            we <= 1'b0;
            a <= '0;
            wd <= '0;
            Funct3 <= '0;
            cnt <= '0;
            rsp_rdata <= '0;
        end else begin
            if (req0_ready || req1_ready) begin
                port <= grant[1];
                last_grant <= grant[1];
                we <= grant[1] ? req1_we : req0_we;
                a <= grant[1] ? req1_addr : req0_addr;
                wd <= grant[1] ? req1_wdata : req0_wdata;
                Funct3 <= grant[1] ? req1_funct3 : req0_funct3;
            end
            if (state == ISSUE) begin
                cnt <= 3'(RD_LATENCY - 1);
                if (we)
                    rsp_rdata <= '0;
            end else if (state == WAIT)
                cnt <= cnt - 3'd1;
            if (last_rd)
                rsp_rdata <= rd;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA loader.
- Serialises accesses and drives the memory's MemRead/MemWrite/a/wd/Funct3 inputs; captures rd and returns it to the winning requester.
- Sits between the datapath and the data memory, replacing the direct control-unit connection.
- One outstanding transaction at a time; round-robin fairness.

Parameters:
- DM_ADDRESS, 9: memory address width, the LSBs of the ALU result.
- DATA_W, 32: data width.
- RD_LATENCY, 1: cycles from issue until memory rd is valid (range 1-7).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_we / req1_we  in  1  1 = store, 0 = load.
- req0_addr / req1_addr  in  DM_ADDRESS  byte address.
- req0_wdata / req1_wdata  in  DATA_W  store data.
- req0_funct3 / req1_funct3  in  3  access size/sign, RISC-V encoding.
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse.
- rsp0_rdata / rsp1_rdata  out  DATA_W  load data; valid only with rsp_valid.
- MemRead, MemWrite  out  1  memory strobes.
- a  out  DM_ADDRESS  memory address.
- wd  out  DATA_W  memory write data.
- Funct3  out  3  memory access size.
- rd  in  DATA_W  memory read data.

Behaviour:
- States (shared package enum):
  - IDLE
  - ISSUE
  - WAIT
  - RESP
- Reset (sync, overrides everything):
  - state = IDLE, last_grant = 1, wait counter = 0.
  - All ready/rsp_valid/MemRead/MemWrite = 0.
  - a, wd, Funct3, rsp_rdata = 0.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, only for the granted port, and only if that port's valid is high.
  - Both valid: grant the port that is not last_grant.
  - One valid: grant that port.
  - On accept edge: latch port id, we, addr, wdata, funct3; set last_grant = winner; go to ISSUE.
- ISSUE (1 cycle):
  - a/wd/Funct3 = latched values.
  - MemWrite = we.
  - MemRead = !we.
  - Store: go to RESP.
  - Load: load counter = RD_LATENCY-1, then go to WAIT, or to RESP if RD_LATENCY = 1.
- WAIT:
  - Hold a/Funct3/MemRead steady, since the memory read path is address-combinational.
  - Decrement the counter; at 0 go to RESP.
  - MemWrite = 0.
- Data capture: rd is captured into rsp_rdata on the edge leaving the last read cycle.
  - That is ISSUE when RD_LATENCY = 1, otherwise the last WAIT cycle.
- RESP (1 cycle):
  - rspN_valid = 1 for the latched port only.
  - Memory strobes = 0.
  - rsp_rdata = captured rd for loads, 0 for stores.
  - Next state = IDLE.
- Timing:
  - Accept at edge T → strobe cycle T+1 → rsp_valid in cycle T+1+RD_LATENCY.
  - Back-to-back throughput: one transaction per RD_LATENCY+2 cycles.
- Invariants:
  - MemRead and MemWrite are never both high.
  - Strobes are 0 in IDLE and RESP.
  - ready and rsp_valid are never asserted for both ports in the same cycle.
- Requester changes while not ready are ignored, with no retention; the requester holds valid until ready.
- Funct3 and addr pass through unmodified, with no alignment check. Alignment and sub-word handling belong to the memory.
- Reset mid-transaction aborts it: no rsp pulse, strobes low from the next cycle, next grant goes to port 0.
- Fairness: with continuous valids on both ports, grants alternate 0,1,0,1.

Decomposition:
- Package dmem_arb_pkg:
  - state_t enum (IDLE, ISSUE, WAIT, RESP).
  - port_id_t (1 bit).
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- Sub-module rr_arb2:
  - Combinational 2-way round-robin grant from valid[1:0] and last_grant.
  - Reused by future shared-resource controllers.

Test Plan:
- Single store: port 0 store, addr=0x010, wdata=0xDEADBEEF, funct3=010 → req0_ready cycle 0; MemWrite=1, a=0x010, wd=0xDEADBEEF cycle 1; rsp0_valid cycle 2, rdata=0.
- Single load (RD_LATENCY=1): port 1 load, addr=0x010, funct3=010, memory returns 0xDEADBEEF → MemRead=1 cycle 1, rsp1_valid cycle 2, rsp1_rdata=0xDEADBEEF, rsp0_valid stays 0.
- Contention after reset: both valid in the same cycle (loads 0x004 and 0x008) → port 0 granted first, port 1 accepted in the next IDLE; subsequent continuous requests alternate.
- RD_LATENCY=3: load at 0x020 → MemRead and a=0x020 held for 3 cycles, rsp_valid 4 cycles after accept, MemWrite never asserted.
- Reset mid-transaction: assert reset during WAIT → next cycle all strobes and rsp_valid are 0, no response pulse; a request from port 1 after reset is granted immediately.
- Funct3 pass-through: SB to 0x013 with funct3=000 → Funct3=000, a=0x013, Wr path untouched, single MemWrite pulse.
